line_cache_k: RTL and testbench
===============================

Name: line_cache_k

Overview:
- Parametrised K-row sliding-window line cache between the edge-detection accelerator and port A of the dual-port image memory.
- Generalises the fixed 3-row cache to ROWS rows, configurable data width and output base address.
- Adds write-priority arbitration, frame start/done handshake and a per-frame window counter.
- Fetches image rows into a ring of row buffers, presents one column of all ROWS rows per accelerator request, and forwards result writes to memory.

Parameters:
- WIDTH, 352, image width in pixels; multiple of PIX_PER_WORD.
- HEIGHT, 288, image height in rows; HEIGHT >= ROWS.
- ROWS, 3, window height (rows cached), 2..7.
- DATA_W, 32, memory word width.
- PIX_PER_WORD, 4, pixels per word; W_WORDS = WIDTH/PIX_PER_WORD.
- ADDR_W, 16, memory address width.
- OUT_BASE, WIDTH*HEIGHT/PIX_PER_WORD, word address of the first result word.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  one-cycle pulse: begin a frame (ignored unless IDLE or DONE)
- en  in  1  accelerator read request: advance one column
- we  in  1  accelerator result write strobe
- di  in  DATA_W  result word
- do_rows  out  ROWS*DATA_W  column data; slice 0 = oldest (top) row
- row_cached  out  1  window valid; en is accepted only while high
- frame_done  out  1  all windows consumed and all writes issued
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory word address
- mem_di  out  DATA_W  write data to memory
- mem_do  in  DATA_W  read data from memory (1-cycle latency)

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk. All state is in a single clk domain.
- Reset: state IDLE; do_rows, row_cached, frame_done, mem_en, mem_we, mem_addr and mem_di all 0; counters and ring pointer 0.
- FSM states: IDLE, FILL, READY, REFILL, DONE.
- IDLE/DONE -> FILL on start:
  - clears frame_done, read pointer, write pointer and window counter;
  - write pointer reloads to OUT_BASE.
- FILL: issues ROWS*W_WORDS sequential reads from address 0. A one-cycle-delayed valid bit stores mem_do into ring slot (issue_idx / W_WORDS). After the last data word lands -> READY.
- READY:
  - row_cached = 1, column counter starts at 0.
  - An en accepted at cycle t drives do_rows with column col of all rows, ordered oldest to newest, at t+1. do_rows holds its value until the next accepted en.
  - en with col = W_WORDS-1 is accepted; row_cached drops the next cycle.
  - The window counter then increments. If it equals HEIGHT-ROWS+1 -> DONE, else -> REFILL.
- REFILL:
  - reads the next image row (W_WORDS words) into the oldest slot; ring pointer advances by 1 mod ROWS.
  - After the last word lands -> READY with col = 0.
- Writes: we is accepted in every state except IDLE.
  - mem_addr = wr_ptr, mem_we = 1, mem_di = di, same cycle; wr_ptr increments.
  - A write has priority over a FILL/REFILL read in the same cycle. The read is deferred one cycle and no read data is lost or reordered.
- en while row_cached = 0: ignored, no state change. we in IDLE: ignored.
- start in FILL, READY or REFILL: ignored.
- DONE: frame_done = 1 and held until the next start. Late writes are still accepted.
- Address arithmetic: read address = row*W_WORDS + col, truncated to ADDR_W; no wrap checking.
- Reset mid-frame: immediate return to IDLE; any in-flight read result is discarded.

Test Plan:
- Common parameters: WIDTH=16, HEIGHT=6, ROWS=3, PIX_PER_WORD=4, W_WORDS=4, OUT_BASE=24. Memory word n holds value n.
- Fill: start -> 12 reads at addresses 0..11, then row_cached=1. 4 en pulses -> do_rows columns {0,4,8}, {1,5,9}, {2,6,10}, {3,7,11}, each one cycle after its en.
- Sliding: consume all 4 windows -> refill reads 12..15, then 16..19, then 20..23. Second window column 0 = {4,8,12}. After the 4th window, frame_done=1 and holds.
- Write arbitration: pulse we with di=0xA5A5A5A5 on every REFILL cycle -> writes land at 24, 25, ... in order. Each refill takes exactly one extra cycle per write; cached data stays correct.
- Ignored inputs: en while row_cached=0 -> no column advance. start during READY -> no restart. we in IDLE -> mem_we stays 0.
- Reset mid-REFILL: assert rst -> all outputs 0 and state IDLE. A following start refetches from address 0.
- ROWS=5 variant, HEIGHT=6: 2 windows. First column 0 = {0,4,8,12,16}; second = {4,8,12,16,20}.

Source files
------------

// File: rtl/line_cache_k.sv
`default_nettype none
// ============================================================================
//  Module      : line_cache_k
//  Description : K-row sliding-window line cache. Fetches image rows from
//                port A of the image memory into a ring of row buffers,
//                presents one column of all cached rows per accelerator
//                request, and forwards accelerator result writes to memory
//                with priority over row fetches.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_cache_k #(
    parameter int WIDTH        = 352,
    parameter int HEIGHT       = 288,
    parameter int ROWS         = 3,
    parameter int DATA_W       = 32,
    parameter int PIX_PER_WORD = 4,
    parameter int ADDR_W       = 16,
    parameter int OUT_BASE     = WIDTH * HEIGHT / PIX_PER_WORD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     en,
    input  logic                     we,
    input  logic [DATA_W-1:0]        di,
    output logic [ROWS*DATA_W-1:0]   do_rows,
    output logic                     row_cached,
    output logic                     frame_done,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_di,
    input  logic [DATA_W-1:0]        mem_do
);

    localparam int C_W_WORDS    = WIDTH / PIX_PER_WORD;
    localparam int C_FILL_WORDS = ROWS * C_W_WORDS;
    localparam int C_WINDOWS    = HEIGHT - ROWS + 1;
    localparam int COL_W        = (C_W_WORDS > 1) ? $clog2(C_W_WORDS) : 1;
    localparam int SLOT_W       = $clog2(ROWS);
    localparam int ISS_W        = $clog2(C_FILL_WORDS + 1);
    localparam int WIN_W        = $clog2(C_WINDOWS + 1);

    localparam logic [ISS_W-1:0]  C_FILL_CNT   = ISS_W'(C_FILL_WORDS);
    localparam logic [ISS_W-1:0]  C_REFILL_CNT = ISS_W'(C_W_WORDS);
    localparam logic [COL_W-1:0]  C_COL_LAST   = COL_W'(C_W_WORDS - 1);
    localparam logic [SLOT_W-1:0] C_SLOT_LAST  = SLOT_W'(ROWS - 1);
    localparam logic [SLOT_W:0]   C_ROWS_EXT   = (SLOT_W + 1)'(ROWS);
    localparam logic [WIN_W-1:0]  C_WIN_LAST   = WIN_W'(C_WINDOWS);
    localparam logic [ADDR_W-1:0] C_OUT_BASE   = ADDR_W'(OUT_BASE);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_READY  = 3'd2,
        S_REFILL = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [COL_W-1:0]         col_q, col_d;             // column presented next
    logic [SLOT_W-1:0]        ptr_q, ptr_d;             // slot holding the oldest row
    logic [ISS_W-1:0]         issue_cnt_q, issue_cnt_d; // reads issued this fetch phase
    logic [COL_W-1:0]         land_col_q, land_col_d;   // destination of the next returning word
    logic [SLOT_W-1:0]        land_slot_q, land_slot_d;
    logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;     // next image word to fetch
    logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d;       // next result word address
    logic [WIN_W-1:0]         win_cnt_q, win_cnt_d;
    logic [ROWS*DATA_W-1:0]   do_rows_q, do_rows_d;
    logic                     rd_valid_q;               // mem_do carries fetched data this cycle

    logic [DATA_W-1:0]        ring_q [ROWS][C_W_WORDS];

    logic                     w_wr_acc;
    logic                     w_rd_need;
    logic                     w_rd_issue;
    logic                     w_land_last;
    logic [WIN_W-1:0]         w_win_next;
    logic [ROWS*DATA_W-1:0]   w_col_data;
    logic [SLOT_W:0]          w_slot_sum;

    // Memory port arbitration: a result write always wins; a pending read waits a cycle.
    always_comb begin
        w_wr_acc   = we && (state_q != S_IDLE);
        w_rd_need  = ((state_q == S_FILL)   && (issue_cnt_q != C_FILL_CNT)) ||
                     ((state_q == S_REFILL) && (issue_cnt_q != C_REFILL_CNT));
        w_rd_issue = w_rd_need && !w_wr_acc;
        mem_en     = w_wr_acc || w_rd_issue;
        mem_we     = w_wr_acc;
        mem_addr   = w_wr_acc ? wr_ptr_q : (w_rd_issue ? rd_addr_q : '0);
        mem_di     = w_wr_acc ? di : '0;
    end

    // Gather column col_q from every slot, oldest row in slice 0.
    always_comb begin
        w_col_data = '0;
        w_slot_sum = '0;
        for (int k = 0; k < ROWS; k++) begin
            w_slot_sum = {1'b0, ptr_q} + (SLOT_W + 1)'(k);
            if (w_slot_sum >= C_ROWS_EXT) begin
                w_slot_sum = w_slot_sum - C_ROWS_EXT;
            end
            w_col_data[k*DATA_W +: DATA_W] = ring_q[w_slot_sum[SLOT_W-1:0]][col_q];
        end
    end

    // Next-state logic for the frame FSM and all counters.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        ptr_d       = ptr_q;
        issue_cnt_d = issue_cnt_q;
        land_col_d  = land_col_q;
        land_slot_d = land_slot_q;
        rd_addr_d   = rd_addr_q;
        wr_ptr_d    = wr_ptr_q;
        win_cnt_d   = win_cnt_q;
        do_rows_d   = do_rows_q;
        w_win_next  = win_cnt_q + 1'b1;
        // In REFILL the landing slot is fixed, so only the column end matters.
        w_land_last = rd_valid_q && (land_col_q == C_COL_LAST) &&
                      ((state_q == S_REFILL) || (land_slot_q == C_SLOT_LAST));

        if (w_wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (w_rd_issue) begin
            issue_cnt_d = issue_cnt_q + 1'b1;
            rd_addr_d   = rd_addr_q + 1'b1;
        end

        if (rd_valid_q) begin
            if (land_col_q == C_COL_LAST) begin
                land_col_d = '0;
                if (state_q == S_FILL) begin
                    land_slot_d = land_slot_q + 1'b1;
                end
            end else begin
                land_col_d = land_col_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_FILL;
                    col_d       = '0;
                    ptr_d       = '0;
                    issue_cnt_d = '0;
                    land_col_d  = '0;
                    land_slot_d = '0;
                    rd_addr_d   = '0;
                    win_cnt_d   = '0;
                    wr_ptr_d    = C_OUT_BASE;
                end
            end
            S_FILL: begin
                if (w_land_last) begin
                    state_d = S_READY;
                    col_d   = '0;
                end
            end
            S_READY: begin
                if (en) begin
                    do_rows_d = w_col_data;
                    if (col_q == C_COL_LAST) begin
                        col_d     = '0;
                        win_cnt_d = w_win_next;
                        if (w_win_next == C_WIN_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            state_d     = S_REFILL;
                            issue_cnt_d = '0;
                            land_col_d  = '0;
                            land_slot_d = ptr_q;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_REFILL: begin
                if (w_land_last) begin
                    state_d = S_READY;
                    col_d   = '0;
                    ptr_d   = (ptr_q == C_SLOT_LAST) ? '0 : ptr_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers; reset drops any read still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            ptr_q       <= '0;
            issue_cnt_q <= '0;
            land_col_q  <= '0;
            land_slot_q <= '0;
            rd_addr_q   <= '0;
            wr_ptr_q    <= '0;
            win_cnt_q   <= '0;
            do_rows_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            ptr_q       <= ptr_d;
            issue_cnt_q <= issue_cnt_d;
            land_col_q  <= land_col_d;
            land_slot_q <= land_slot_d;
            rd_addr_q   <= rd_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            win_cnt_q   <= win_cnt_d;
            do_rows_q   <= do_rows_d;
            rd_valid_q  <= w_rd_issue;
        end
    end

    // Row buffer storage: capture memory data one cycle after each issued read.
    always_ff @(posedge clk) begin
        if (rd_valid_q) begin
            ring_q[land_slot_q][land_col_q] <= mem_do;
        end
    end

    assign do_rows    = do_rows_q;
    assign row_cached = (state_q == S_READY);
    assign frame_done = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_line_cache_k.sv
`default_nettype none
// ============================================================================
//  Module      : tb_line_cache_k
//  Description : Scoreboard bench for line_cache_k (ROWS=3 and ROWS=5).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_line_cache_k;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start, en, we;
    logic [31:0]  di;
    logic [95:0]  do_rows;
    logic         row_cached, frame_done, mem_en, mem_we;
    logic [15:0]  mem_addr;
    logic [31:0]  mem_di, mem_do;

    logic         start2, en2, we2;
    logic [31:0]  di2;
    logic [159:0] do_rows2;
    logic         row_cached2, frame_done2, mem_en2, mem_we2;
    logic [15:0]  mem_addr2;
    logic [31:0]  mem_di2, mem_do2;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] rd_q  [$];
    logic [47:0] wr_q  [$];
    logic [95:0] col_q [$];
    logic        en_pend = 1'b0;

    line_cache_k #(.WIDTH(16), .HEIGHT(6), .ROWS(3), .DATA_W(32), .PIX_PER_WORD(4),
                   .ADDR_W(16), .OUT_BASE(24)) dut (
        .clk(clk), .rst(rst), .start(start), .en(en), .we(we), .di(di),
        .do_rows(do_rows), .row_cached(row_cached), .frame_done(frame_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di),
        .mem_do(mem_do)
    );

    line_cache_k #(.WIDTH(16), .HEIGHT(6), .ROWS(5), .DATA_W(32), .PIX_PER_WORD(4),
                   .ADDR_W(16), .OUT_BASE(24)) dut5 (
        .clk(clk), .rst(rst), .start(start2), .en(en2), .we(we2), .di(di2),
        .do_rows(do_rows2), .row_cached(row_cached2), .frame_done(frame_done2),
        .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_di(mem_di2),
        .mem_do(mem_do2)
    );

    // Image memory: word n holds value n, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_do <= {16'h0, mem_addr};
        if (mem_en2 && !mem_we2) mem_do2 <= {16'h0, mem_addr2};
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_unexp(input string nm, input logic [255:0] act);
        vectors++;
        miscompares++;
        $display("FAIL %s: unexpected output %0h, nothing expected", nm, act);
    endtask

    function automatic logic [95:0] col3(input int w, input int c);
        logic [95:0] r;
        r = '0;
        for (int k = 0; k < 3; k++) r[k*32 +: 32] = 32'((w + k) * 4 + c);
        return r;
    endfunction

    function automatic logic [159:0] col5(input int w, input int c);
        logic [159:0] r;
        r = '0;
        for (int k = 0; k < 5; k++) r[k*32 +: 32] = 32'((w + k) * 4 + c);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int which, input string nm);
        int n;
        n = 0;
        while (((which == 1) ? row_cached : row_cached2) !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk(nm, 256'((which == 1) ? row_cached : row_cached2), 256'(1));
    endtask

    task automatic push_reads(input int first, input int count);
        for (int a = 0; a < count; a++) rd_q.push_back(16'(first + a));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_do_rows"},    256'(do_rows),    256'(0));
        chk({tag, "_row_cached"}, 256'(row_cached), 256'(0));
        chk({tag, "_frame_done"}, 256'(frame_done), 256'(0));
        chk({tag, "_mem_en"},     256'(mem_en),     256'(0));
        chk({tag, "_mem_we"},     256'(mem_we),     256'(0));
        chk({tag, "_mem_addr"},   256'(mem_addr),   256'(0));
        chk({tag, "_mem_di"},     256'(mem_di),     256'(0));
    endtask

    // Monitor: compares every memory access and every presented column against the queues.
    always @(negedge clk) begin
        logic [47:0] w_exp;
        if (rst) begin
            en_pend = 1'b0;
        end else begin
            if (en_pend) begin
                if (col_q.size() == 0) fail_unexp("column", 256'(do_rows));
                else chk("column", 256'(do_rows), 256'(col_q.pop_front()));
            end
            en_pend = en && row_cached;
            if (mem_en && !mem_we) begin
                if (rd_q.size() == 0) fail_unexp("rd_addr", 256'(mem_addr));
                else chk("rd_addr", 256'(mem_addr), 256'(rd_q.pop_front()));
            end
            if (mem_we) begin
                if (wr_q.size() == 0) begin
                    fail_unexp("wr_addr", 256'(mem_addr));
                end else begin
                    w_exp = wr_q.pop_front();
                    chk("wr_addr", 256'(mem_addr), 256'(w_exp[47:32]));
                    chk("wr_data", 256'(mem_di),   256'(w_exp[31:0]));
                end
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; en = 1'b0; we = 1'b0; di = '0;
        start2 = 1'b0; en2 = 1'b0; we2 = 1'b0; di2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        step();
        rst = 1'b0;

        // Write in IDLE must not reach memory.
        we = 1'b1; di = 32'hDEADBEEF;
        @(negedge clk);
        chk("idle_we_blocked", 256'(mem_we), 256'(0));
        step();
        we = 1'b0;

        // Frame 1: fill, with a stray en while not cached.
        push_reads(0, 12);
        start = 1'b1; step(); start = 1'b0;
        en = 1'b1; step(); en = 1'b0;
        wait_ready(1, "fill_ready");

        // start in READY is ignored.
        start = 1'b1; step(); start = 1'b0;
        @(negedge clk);
        chk("start_ignored_ready", 256'(row_cached), 256'(1));
        step();

        for (int w = 0; w < 4; w++) begin
            for (int c = 0; c < 4; c++) begin
                col_q.push_back(col3(w, c));
                en = 1'b1; step(); en = 1'b0;
                if (c == 1) begin
                    step();
                    @(negedge clk);
                    chk("do_rows_hold", 256'(do_rows), 256'(col3(w, 1)));
                    step();
                end
            end
            if (w < 3) begin
                push_reads((w + 3) * 4, 4);
                if (w >= 1) begin
                    we = 1'b1; di = 32'hA5A5A5A5;
                    wr_q.push_back({16'(24 + w - 1), 32'hA5A5A5A5});
                end
                n = 0;
                while (n < 40) begin
                    @(negedge clk);
                    if (row_cached) break;
                    n++;
                    step();
                    we = 1'b0;
                end
                we = 1'b0;
                chk("refill_cycles", 256'(n), 256'((w >= 1) ? 6 : 5));
                step();
            end else begin
                @(negedge clk);
                chk("frame_done_set", 256'(frame_done), 256'(1));
                chk("done_row_cached", 256'(row_cached), 256'(0));
                repeat (3) step();
                @(negedge clk);
                chk("frame_done_held", 256'(frame_done), 256'(1));
                step();
            end
        end

        // Late write in DONE.
        we = 1'b1; di = 32'h12345678;
        wr_q.push_back({16'd26, 32'h12345678});
        step(); we = 1'b0;
        @(negedge clk);
        chk("done_after_write", 256'(frame_done), 256'(1));
        step();

        // Frame 2, reset in the middle of the first refill.
        push_reads(0, 12);
        start = 1'b1; step(); start = 1'b0;
        @(negedge clk);
        chk("done_cleared", 256'(frame_done), 256'(0));
        step();
        wait_ready(1, "fill2_ready");
        for (int c = 0; c < 4; c++) begin
            col_q.push_back(col3(0, c));
            en = 1'b1; step(); en = 1'b0;
        end
        push_reads(12, 1);
        step();
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        step();
        rst = 1'b0;

        // Restart after reset fetches from address 0 again.
        push_reads(0, 12);
        start = 1'b1; step(); start = 1'b0;
        wait_ready(1, "fill3_ready");
        col_q.push_back(col3(0, 0));
        en = 1'b1; step(); en = 1'b0;
        step();

        // ROWS=5 variant: two windows.
        start2 = 1'b1; step(); start2 = 1'b0;
        for (int w = 0; w < 2; w++) begin
            wait_ready(2, "r5_ready");
            for (int c = 0; c < 4; c++) begin
                en2 = 1'b1; step(); en2 = 1'b0;
                @(negedge clk);
                chk("r5_column", 256'(do_rows2), 256'(col5(w, c)));
                if (w == 1 && c == 3) chk("r5_frame_done", 256'(frame_done2), 256'(1));
                step();
            end
        end

        step();
        chk("rd_queue_drained",  256'(rd_q.size()),  256'(0));
        chk("wr_queue_drained",  256'(wr_q.size()),  256'(0));
        chk("col_queue_drained", 256'(col_q.size()), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
